// File: rtl/imm_gen_stage.sv
// Registered I/S/B/J/U immediate generator with a 2-entry skid buffer and valid/ready on both sides.
// Define IMM_GEN_ZICSR_EN to decode imm_src 101 as the CSR zimm; otherwise 101 is reserved.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// FULL  | main entry drives outputs, skid empty
// SKID  | main and skid both valid, in_ready=0
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int SRC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [SRC_W-1:0] imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic             out_illegal
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [SRC_W-1:0] SRC_I = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_S = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_B = SRC_W'(2);
  localparam logic [SRC_W-1:0] SRC_J = SRC_W'(3);
  localparam logic [SRC_W-1:0] SRC_U = SRC_W'(4);
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [SRC_W-1:0] SRC_Z = SRC_W'(5);
`endif

  logic [1:0]      state, state_nxt;
  logic            in_ready_q;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic            main_ill, skid_ill;
  logic            accept, xfer;

  // zimm has bit 31 clear, so the common sign extension also zero-extends it
  always_comb begin
    imm32   = '0;
    dec_ill = 1'b0;
    case (imm_src)
      SRC_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      SRC_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      SRC_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      SRC_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      SRC_U: imm32 = {instr[31:12], 12'b0};
`ifdef IMM_GEN_ZICSR_EN
      SRC_Z: imm32 = {27'b0, instr[19:15]};
`endif
      default: dec_ill = 1'b1;
    endcase
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  assign accept = in_valid & in_ready_q;
  assign xfer   = (state != ST_EMPTY) & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL: begin
        if (xfer && !accept)      state_nxt = ST_EMPTY;
        else if (!xfer && accept) state_nxt = ST_SKID;
      end
      ST_SKID:  if (out_ready) state_nxt = ST_FULL;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_imm   <= '0;
      main_ill   <= 1'b0;
      skid_imm   <= '0;
      skid_ill   <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_SKID);
      if (!flush) begin
        case (state)
          ST_EMPTY: if (accept) begin
            main_imm <= dec_imm;
            main_ill <= dec_ill;
          end
          ST_FULL: begin
            if (accept && xfer) begin
              main_imm <= dec_imm;
              main_ill <= dec_ill;
            end else if (accept) begin
              skid_imm <= dec_imm;
              skid_ill <= dec_ill;
            end
          end
          ST_SKID: if (out_ready) begin
            main_imm <= skid_imm;
            main_ill <= skid_ill;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != ST_EMPTY);
  assign imm         = main_imm;
  assign out_illegal = main_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one input stream.
// Expected zimm results follow IMM_GEN_ZICSR_EN.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] imm;
  logic        in_ready_64, out_valid_64, out_illegal_64;
  logic [63:0] imm_64;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] got[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .SRC_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(64), .SRC_W(3)) dut_64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid_64), .out_ready(out_ready),
    .imm(imm_64), .out_illegal(out_illegal_64)
  );

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) got.push_back(imm);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] v_instr [9];
  logic [2:0]  v_src   [9];
  logic [31:0] v_e32   [9];
  logic [63:0] v_e64   [9];
  logic        v_ill   [9];

  initial begin
    v_instr[0] = 32'hFFF00093; v_src[0] = 3'b000; v_e32[0] = 32'hFFFFFFFF; v_e64[0] = 64'hFFFFFFFFFFFFFFFF; v_ill[0] = 1'b0;
    v_instr[1] = 32'hFE112E23; v_src[1] = 3'b001; v_e32[1] = 32'hFFFFFFFC; v_e64[1] = 64'hFFFFFFFFFFFFFFFC; v_ill[1] = 1'b0;
    v_instr[2] = 32'hFE000EE3; v_src[2] = 3'b010; v_e32[2] = 32'hFFFFFFFC; v_e64[2] = 64'hFFFFFFFFFFFFFFFC; v_ill[2] = 1'b0;
    v_instr[3] = 32'h0080006F; v_src[3] = 3'b011; v_e32[3] = 32'h00000008; v_e64[3] = 64'h0000000000000008; v_ill[3] = 1'b0;
    v_instr[4] = 32'h800000B7; v_src[4] = 3'b100; v_e32[4] = 32'h80000000; v_e64[4] = 64'hFFFFFFFF80000000; v_ill[4] = 1'b0;
    v_instr[5] = 32'h123450B7; v_src[5] = 3'b100; v_e32[5] = 32'h12345000; v_e64[5] = 64'h0000000012345000; v_ill[5] = 1'b0;
`ifdef IMM_GEN_ZICSR_EN
    v_instr[6] = 32'h800A8073; v_src[6] = 3'b101; v_e32[6] = 32'h00000015; v_e64[6] = 64'h15;               v_ill[6] = 1'b0;
`else
    v_instr[6] = 32'h800A8073; v_src[6] = 3'b101; v_e32[6] = 32'h00000000; v_e64[6] = 64'h0;                v_ill[6] = 1'b1;
`endif
    v_instr[7] = 32'hFFFFFFFF; v_src[7] = 3'b111; v_e32[7] = 32'h00000000; v_e64[7] = 64'h0;                v_ill[7] = 1'b1;
    v_instr[8] = 32'hFFFFFFFF; v_src[8] = 3'b110; v_e32[8] = 32'h00000000; v_e64[8] = 64'h0;                v_ill[8] = 1'b1;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = '0; imm_src = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm",       64'(imm),       64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // streaming at full rate: each vector shows up one cycle after it is offered
    for (int i = 0; i < 9; i++) begin
      instr = v_instr[i]; imm_src = v_src[i]; in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i),   64'(out_valid),      64'd1);
      chk($sformatf("vec%0d_imm", i),     64'(imm),            64'(v_e32[i]));
      chk($sformatf("vec%0d_ill", i),     64'(out_illegal),    64'(v_ill[i]));
      chk($sformatf("vec%0d_imm64", i),   imm_64,              v_e64[i]);
      chk($sformatf("vec%0d_ill64", i),   64'(out_illegal_64), 64'(v_ill[i]));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // backpressure: A held, B in skid, C refused until drain
    got.delete();
    out_ready = 1'b0; imm_src = 3'b000;
    instr = 32'h00100093; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_a_imm", 64'(imm), 64'd1);
    chk("bp_a_rdy", 64'(in_ready), 64'd1);
    instr = 32'h00200093;
    @(negedge clk);
    chk("bp_b_rdy", 64'(in_ready), 64'd0);
    chk("bp_b_hold", 64'(imm), 64'd1);
    instr = 32'h00300093;
    repeat (2) @(negedge clk);
    chk("bp_c_rdy", 64'(in_ready), 64'd0);
    chk("bp_c_hold", 64'(imm), 64'd1);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_b", 64'(imm), 64'd2);
    chk("bp_drain_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_drain_c", 64'(imm), 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_count", 64'(got.size()), 64'd3);
    if (got.size() == 3) begin
      chk("bp_ord0", 64'(got[0]), 64'd1);
      chk("bp_ord1", 64'(got[1]), 64'd2);
      chk("bp_ord2", 64'(got[2]), 64'd3);
    end

    // flush while SKID with a concurrent offer
    got.delete();
    out_ready = 1'b0;
    instr = 32'h00400093; in_valid = 1'b1;
    @(negedge clk);
    instr = 32'h00500093;
    @(negedge clk);
    chk("fl_skid_rdy", 64'(in_ready), 64'd0);
    instr = 32'h00600093; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy",   64'(in_ready),  64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("fl_nothing", 64'(got.size()), 64'd0);
    instr = 32'h00700093; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("fl_after_imm", 64'(imm), 64'd7);
    @(negedge clk);

    // reset while SKID, main holding nonzero and skid holding an illegal entry
    got.delete();
    out_ready = 1'b0;
    instr = 32'h00900093; imm_src = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    instr = 32'hFFFFFFFF; imm_src = 3'b111;
    @(negedge clk);
    chk("rs_pre_imm", 64'(imm), 64'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rs_valid",   64'(out_valid),   64'd0);
    chk("rs_imm",     64'(imm),         64'd0);
    chk("rs_ill",     64'(out_illegal), 64'd0);
    chk("rs_rdy",     64'(in_ready),    64'd1);
    chk("rs_imm64",   imm_64,           64'd0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rs_nothing", 64'(got.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
